// File: rtl/sat_decoder_pkg.sv
// Shared types and the saturating decode helper for the sat_decoder_pipe block.
// Words are built at MAX_OUT_W bits and narrowed by the instantiating module.
package sat_decoder_pkg;

  localparam int unsigned MAX_OUT_W = 64;

  typedef enum logic [0:0] {
    MODE_ONEHOT = 1'b0,
    MODE_THERM  = 1'b1
  } mode_e;

  typedef struct packed {
    logic [MAX_OUT_W-1:0] word;
    logic                 sat;
  } sat_entry_t;

  // Codes at or above sat all collapse onto bit sat.
  function automatic logic [MAX_OUT_W-1:0] sat_decode(input logic [31:0] code,
                                                       input mode_e       mode,
                                                       input logic [31:0] sat);
    logic [31:0]          k;
    logic [MAX_OUT_W-1:0] w;
    k = (code >= sat) ? sat : code;
    w = '0;
    for (int i = 0; i < MAX_OUT_W; i++) begin
      if (mode == MODE_THERM) w[i] = (32'(i) <= k);
      else                    w[i] = (32'(i) == k);
    end
    return w;
  endfunction

endpackage

// File: rtl/sat_decoder_pipe_if.sv
// Handshake bundle between the code producer, the decoder and the one-hot consumer.
interface sat_decoder_pipe_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_code;
  logic             in_therm;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_word;
  logic             out_sat;
  logic [CNT_W-1:0] sat_cnt;
  logic             sat_clr;

  modport master (
    output in_valid, in_code, in_therm, out_ready, sat_clr,
    input  in_ready, out_valid, out_word, out_sat, sat_cnt
  );

  modport slave (
    input  in_valid, in_code, in_therm, out_ready, sat_clr,
    output in_ready, out_valid, out_word, out_sat, sat_cnt
  );
endinterface

// File: rtl/sat_decoder_fifo2.sv
// Two-entry output buffer with registered valid/ready; the head register drives the
// output directly so nothing combinational reaches the consumer.
module sat_decoder_fifo2
  import sat_decoder_pkg::*;
#(
  parameter type entry_t = sat_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_valid_i,
  output logic   push_ready_o,
  input  entry_t push_data_i,
  output logic   pop_valid_o,
  input  logic   pop_ready_i,
  output entry_t pop_data_o
);

  entry_t     head_q, head_d, tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       outValid_q, outValid_d, inReady_q, inReady_d;
  logic       push, pop;

  assign push_ready_o = inReady_q & ~rst;
  assign push         = push_valid_i & push_ready_o;
  assign pop          = outValid_q & pop_ready_i;
  assign pop_valid_o  = outValid_q;
  assign pop_data_o   = head_q;

  // Push+pop only happens at occupancy 1, where the new word replaces the head.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data_i;
        else                 tail_d = push_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11:   head_d = push_data_i;
      default: ;
    endcase
    outValid_d = (count_d != 2'd0);
    inReady_d  = (count_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      outValid_q <= outValid_d;
      inReady_q  <= inReady_d;
    end
  end

endmodule

// File: rtl/sat_decoder_pipe.sv
// Saturating one-hot/thermometer decoder: decode on acceptance, buffer the result
// in a two-entry FIFO, and count how many accepted codes hit the saturation bucket.
module sat_decoder_pipe
  import sat_decoder_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16,
  parameter int SAT   = 8,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  sat_decoder_pipe_if.slave bus
);

  typedef struct packed {
    logic [OUT_W-1:0] word;
    logic             sat;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t           decEntry, headEntry;
  logic [IN_W-1:0]  code;
  logic             fifoReady, fifoValid, push, satHit;
  logic [CNT_W-1:0] satCnt_q, satCnt_d;

  assign code          = bus.in_code;
  assign decEntry.word = OUT_W'(sat_decode(32'(code), mode_e'(bus.in_therm), 32'(SAT)));
  assign decEntry.sat  = (32'(code) >= 32'(SAT));
  assign push          = bus.in_valid & fifoReady;
  assign satHit        = push & decEntry.sat;

  sat_decoder_fifo2 #(.entry_t(entry_t)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (bus.in_valid),
    .push_ready_o (fifoReady),
    .push_data_i  (decEntry),
    .pop_valid_o  (fifoValid),
    .pop_ready_i  (bus.out_ready),
    .pop_data_o   (headEntry)
  );

  // A clear that coincides with a saturated accept keeps that event.
  always_comb begin
    satCnt_d = satCnt_q;
    if (bus.sat_clr)                         satCnt_d = satHit ? CNT_W'(1) : '0;
    else if (satHit && satCnt_q != CNT_MAX)  satCnt_d = satCnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) satCnt_q <= '0;
    else     satCnt_q <= satCnt_d;
  end

  assign bus.in_ready  = fifoReady;
  assign bus.out_valid = fifoValid;
  assign bus.out_word  = headEntry.word;
  assign bus.out_sat   = headEntry.sat;
  assign bus.sat_cnt   = satCnt_q;

endmodule

// File: tb/tb_sat_decoder_pipe.sv
// Directed bench for sat_decoder_pipe: default-parameter instance A for decode,
// buffering and reset; a CNT_W=2 instance B for the sticky saturation counter.
module tb_sat_decoder_pipe;

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   passCount  = 0;

  sat_decoder_pipe_if #(.IN_W(4), .OUT_W(16), .CNT_W(8)) busA ();
  sat_decoder_pipe_if #(.IN_W(4), .OUT_W(16), .CNT_W(2)) busB ();

  sat_decoder_pipe #(.IN_W(4), .OUT_W(16), .SAT(8), .CNT_W(8)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  sat_decoder_pipe #(.IN_W(4), .OUT_W(16), .SAT(8), .CNT_W(2)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  always #5 clk = ~clk;

  // Drive one instance's inputs, then move to just past the next rising edge.
  task automatic applyStimulus(input bit sel, input logic v, input logic [3:0] code,
                               input logic therm, input logic rdy, input logic clr);
    if (!sel) begin
      busA.in_valid = v; busA.in_code = code; busA.in_therm = therm;
      busA.out_ready = rdy; busA.sat_clr = clr;
    end else begin
      busB.in_valid = v; busB.in_code = code; busB.in_therm = therm;
      busB.out_ready = rdy; busB.sat_clr = clr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else             passCount++;
  endtask

  initial begin
    logic [16:0] expWord;
    rst = 1'b1;
    busA.in_valid = 0; busA.in_code = 0; busA.in_therm = 0; busA.out_ready = 0; busA.sat_clr = 0;
    busB.in_valid = 0; busB.in_code = 0; busB.in_therm = 0; busB.out_ready = 0; busB.sat_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("rst_out_valid", 32'(busA.out_valid), 32'd0);
    checkOutput("rst_in_ready",  32'(busA.in_ready),  32'd1);
    checkOutput("rst_word_sat",  32'({busA.out_sat, busA.out_word}), 32'd0);
    checkOutput("rst_sat_cnt",   32'(busA.sat_cnt),   32'd0);

    // One-hot sweep, consumer always ready: each word is visible one cycle after acceptance.
    for (int c = 0; c < 16; c++) begin
      applyStimulus(0, 1, 4'(c), 0, 1, 0);
      expWord = (c < 8) ? {1'b0, 16'h0001 << c} : {1'b1, 16'h0100};
      checkOutput($sformatf("onehot_%0d", c), 32'({busA.out_sat, busA.out_word}), 32'(expWord));
    end
    checkOutput("onehot_sat_cnt", 32'(busA.sat_cnt), 32'd8);

    applyStimulus(0, 1, 4'd3, 1, 1, 0);
    checkOutput("therm_3",  32'({busA.out_sat, busA.out_word}), 32'h0000F);
    applyStimulus(0, 1, 4'd8, 1, 1, 0);
    checkOutput("therm_8",  32'({busA.out_sat, busA.out_word}), 32'h101FF);
    applyStimulus(0, 1, 4'd12, 1, 1, 0);
    checkOutput("therm_12", 32'({busA.out_sat, busA.out_word}), 32'h101FF);
    checkOutput("therm_sat_cnt", 32'(busA.sat_cnt), 32'd10);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("drain_valid", 32'(busA.out_valid), 32'd0);

    // Back-pressure: two words absorbed, the third code is refused.
    applyStimulus(0, 1, 4'd1, 0, 0, 0);
    checkOutput("bp_ready_1", 32'(busA.in_ready), 32'd1);
    applyStimulus(0, 1, 4'd2, 0, 0, 0);
    checkOutput("bp_ready_2", 32'(busA.in_ready), 32'd0);
    applyStimulus(0, 1, 4'd3, 0, 0, 0);
    checkOutput("bp_ready_3", 32'(busA.in_ready), 32'd0);
    checkOutput("bp_hold",    32'({busA.out_valid, busA.out_word}), 32'h10002);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("bp_second",  32'({busA.out_valid, busA.out_word}), 32'h10004);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("bp_empty",   32'(busA.out_valid), 32'd0);

    // Push and pop together at occupancy 1.
    applyStimulus(0, 1, 4'd5, 0, 1, 0);
    checkOutput("pp_first",  32'(busA.out_word), 32'h0020);
    applyStimulus(0, 1, 4'd6, 0, 1, 0);
    checkOutput("pp_second", 32'(busA.out_word), 32'h0040);
    checkOutput("pp_ready",  32'(busA.in_ready), 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("pp_occ1",   32'(busA.out_valid), 32'd0);

    // Sticky 2-bit counter, then clear with and without a coincident saturated accept.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 4'(8 + i), 0, 1, 0);
      if (i == 1) checkOutput("cnt_two", 32'(busB.sat_cnt), 32'd2);
    end
    checkOutput("cnt_sticky", 32'(busB.sat_cnt), 32'd3);
    applyStimulus(1, 1, 4'd9, 0, 1, 1);
    checkOutput("cnt_clr_hit", 32'(busB.sat_cnt), 32'd1);
    applyStimulus(1, 0, 0, 0, 1, 1);
    checkOutput("cnt_clr",     32'(busB.sat_cnt), 32'd0);
    applyStimulus(1, 0, 0, 0, 1, 0);

    // Reset with a full buffer discards everything.
    applyStimulus(0, 1, 4'd9, 0, 0, 0);
    applyStimulus(0, 1, 4'd10, 0, 0, 0);
    checkOutput("full_ready", 32'(busA.in_ready), 32'd0);
    checkOutput("full_cnt",   32'(busA.sat_cnt),  32'd12);
    rst = 1'b1;
    applyStimulus(0, 1, 4'd11, 0, 0, 0);
    checkOutput("mid_rst_valid", 32'(busA.out_valid), 32'd0);
    checkOutput("mid_rst_word",  32'({busA.out_sat, busA.out_word}), 32'd0);
    checkOutput("mid_rst_cnt",   32'(busA.sat_cnt), 32'd0);
    checkOutput("mid_rst_ready", 32'(busA.in_ready), 32'd0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_ready", 32'(busA.in_ready), 32'd1);
    checkOutput("post_rst_valid", 32'(busA.out_valid), 32'd0);
    checkOutput("post_rst_cnt",   32'(busA.sat_cnt), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sat_decoder_pipe.md
# sat_decoder_pipe

Parametrised, pipelined saturating binary-to-one-hot/thermometer decoder with valid/ready handshakes on both sides. Each accepted code below `SAT` sets one output bit. Each code at or above `SAT` sets bit `SAT`. Decoded words pass through a 2-entry output buffer so that downstream back-pressure never drops a word. A saturating event counter records how many accepted codes hit the saturation bucket. The block sits between a code-producing control path and one-hot consumers, and generalises the fixed 4-to-16, threshold-8 decoder used today.

## Interface
Parameters:
- `IN_W`, default 4: input code width.
- `OUT_W`, default 16: output word width. Legal range: `SAT` < `OUT_W` ≤ 2**`IN_W`.
- `SAT`, default 8: saturation threshold. Legal range: 1 ≤ `SAT` ≤ 2**`IN_W`-1.
- `CNT_W`, default 8: width of the saturation counter.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: an input code is presented.
- `in_ready`, out, 1: the block can accept a code this cycle.
- `in_code`, in, `IN_W`: binary code.
- `in_therm`, in, 1: mode for this code. 0 = one-hot, 1 = thermometer. Captured together with the code.
- `out_valid`, out, 1: a decoded word is presented.
- `out_ready`, in, 1: the consumer accepts the word.
- `out_word`, out, `OUT_W`: decoded word.
- `out_sat`, out, 1: the presented word came from a saturated code.
- `sat_cnt`, out, `CNT_W`: count of accepted saturated codes.
- `sat_clr`, in, 1: clears `sat_cnt`.

## Operation
- Decode index: k = min(`in_code`, `SAT`).
- One-hot mode: only bit k is set.
- Thermometer mode: bits 0 through k are set, all others clear.
- Bits above `SAT` are always 0.
- `out_sat` = (`in_code` ≥ `SAT`).
- The full code space is covered; there is no default or illegal branch.
- Acceptance: a code is accepted when `in_valid` and `in_ready` are both high. Decoding happens before storage; each buffer entry holds {word, sat}.
- Buffer: 2-entry FIFO with occupancy 0, 1 or 2.
  - `in_ready` = (occupancy < 2). It is registered-equivalent and does not combinationally depend on `out_ready`.
  - `out_valid` = (occupancy > 0).
  - Head entry drives `out_word`/`out_sat`. Both hold stable while `out_valid` is high and `out_ready` is low.
- Occupancy transitions:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle at occupancy 1: occupancy stays 1. The new word becomes head next cycle.
  - At occupancy 2 no push is possible. A pop frees a slot, which becomes visible in the following cycle.
  - Pop at occupancy 0 is impossible, because `out_valid` is low.
- Counter:
  - +1 per accepted saturated code. Sticks at 2**`CNT_W`-1.
  - `sat_clr` alone: 0 next cycle.
  - `sat_clr` together with an accepted saturated code: 1, so no event is lost.
- Reset:
  - Occupancy = 0, `out_valid` = 0, `in_ready` = 1 in the cycle after reset is released.
  - `out_word` = 0, `out_sat` = 0, `sat_cnt` = 0.
  - Reset mid-transfer discards buffered words with no partial output.
  - `in_valid` is ignored while `rst` is high, and `in_ready` is 0 during reset.

## Timing
- Latency: a code accepted in cycle n appears on `out_word` in cycle n+1 when the buffer was empty.
- Throughput: one word per cycle while `out_ready` is held high.
- With `out_ready` low, two words are absorbed, then `in_ready` drops in the cycle after the second acceptance.
- `sat_cnt` updates in the cycle after acceptance.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- The package `sat_decoder_pkg` holds:
  - the mode enum (`MODE_ONEHOT`, `MODE_THERM`);
  - the entry struct type {word, sat};
  - the function `sat_decode(code, therm)`, as a parametrised function or a localparam-sized helper.
- Sub-module `sat_decoder_fifo2`: the 2-entry storage and the handshake logic.
- The top level holds the decode and the counter.
- The decode uses `unique casez` over the code, or an equivalent loop. The structure stays triplication-friendly: plain registers, no latches, and every register is reset.

## Test plan
- Default parameters, one-hot mode, `out_ready`=1, codes 0 through 15 back-to-back:
  - codes 0–7 → `out_word` 0x0001 through 0x0080, each one cycle after acceptance;
  - codes 8–15 → 0x0100 with `out_sat`=1;
  - `sat_cnt`=8 afterwards.
- Thermometer mode, codes 3, 8 and 12 → 0x000F, 0x01FF, 0x01FF; `out_sat` = 0, 1, 1.
- Back-pressure:
  - hold `out_ready`=0 and present codes 1, 2, 3 → only 1 and 2 are accepted, and `in_ready`=0 from the third cycle;
  - release `out_ready` → 0x0002 then 0x0004 in order, with no loss or duplication.
- Occupancy 1 with push and pop in the same cycle → occupancy stays 1 and the stream order is preserved.
- Counter:
  - `CNT_W`=2, six saturated codes → `sat_cnt` sticks at 3;
  - `sat_clr` together with a saturated accept → `sat_cnt`=1.
- Assert `rst` with the buffer holding 2 entries → next cycle `out_valid`=0, `out_word`=0, `sat_cnt`=0, and `in_ready`=1 after release.
